writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL provide ex_valid  input  1  execute stage presents a result this cycle.
REQ-004 SHALL provide ex_ready  output  1  writeback accepts the presented result this cycle.
REQ-005 SHALL provide rd_index  input  5, result  input  32, need_write_rd  input  1: execute-stage destination, value, write request.
REQ-006 SHALL provide wb_stall  input  1  hold the pending entry and refuse new input.
REQ-007 SHALL provide flush  input  1  discard the pending, uncommitted entry.
REQ-008 SHALL provide rs1_index, rs2_index  input  5 each  decode read addresses.
REQ-009 SHALL provide rs1_data, rs2_data  output  32 each  bypassed read data to decode.
REQ-010 SHALL provide wb_valid  output  1, wb_rd_index  output  5, wb_data  output  32, wb_we  output  1: the commit observed this cycle.
REQ-011 SHALL provide instret  output  64  count of retired instructions.

Function
REQ-012 SHALL hold one pending entry {valid, rd, data, we}; states EMPTY (valid=0) and FULL (valid=1).
REQ-013 SHALL drive ex_ready = ~wb_stall, combinationally, independent of ex_valid.
REQ-014 SHALL capture on edge when ex_valid & ex_ready; we = need_write_rd & (rd_index != 0).
REQ-015 SHALL commit a FULL entry on the first edge with wb_stall=0: write data to register rd if we, increment instret; commit and a new capture in the same edge both occur (back-to-back, 1 result/cycle).
REQ-016 SHALL drive wb_valid, wb_rd_index, wb_data, wb_we from the pending entry, gated by ~wb_stall & ~flush, as a combinational commit indication.
REQ-017 SHALL, while wb_stall=1, keep the entry and register file unchanged; FULL stays FULL, EMPTY stays EMPTY.
REQ-018 SHALL, on flush=1, clear valid at the edge without committing and without capturing; flush overrides capture, commit and stall.
REQ-019 SHALL read-latency: execute result visible in the register file 2 edges after presentation (capture edge, commit edge).
REQ-020 SHALL resolve rs*_data priority: index 0 -> 0; pending valid & we & rd match -> pending data; else register file content (pending includes stalled entries).
REQ-021 SHALL keep register x0 constant 0; writes to x0 are never performed and never bypassed.
REQ-022 SHALL count instret modulo 2^64; wrap from all-ones to 0 silently; non-writing commits (stores, branches) also count.

Reset
REQ-023 SHALL on rst=1 at an edge clear valid, instret and all 31 writable registers to 0; rst overrides flush, stall, capture.
REQ-024 SHALL drop a pending entry when reset arrives mid-operation; it is never committed.
REQ-025 SHALL drive ex_ready=~wb_stall, wb_valid=0, wb_we=0, wb_rd_index=0, wb_data=0, rs*_data=0 and instret=0 in the cycle after reset.

Configuration
REQ-026 SHALL, with WB_INSTRET_EN defined, implement the 64-bit instret counter per REQ-022.
REQ-027 SHALL, without WB_INSTRET_EN, implement no counter flops and tie instret to 0; all other behaviour unchanged.

Structure
REQ-028 SHALL place XLEN=32, REG_COUNT=32, reg_index_t (5-bit) and the pending-entry struct typedef in shared package rv32_pkg.
REQ-029 SHALL isolate storage in sub-module register_file (2 async read ports, 1 sync write port, x0 hardwired, sync reset); bypass and control logic remain in writeback_unit.

Verification
REQ-030 SHALL test back-to-back: results x5=0x11, x6=0x22 on consecutive cycles -> both committed on consecutive edges, instret +2.
REQ-031 SHALL test bypass: x7=0xDEADBEEF pending, rs1_index=7 same cycle -> rs1_data=0xDEADBEEF; rs2_index=0 -> 0.
REQ-032 SHALL test x0 write: rd_index=0, result=0x1234, need_write_rd=1 -> wb_we=0, read x0=0, instret +1.
REQ-033 SHALL test stall then flush: x9=0x55 captured, wb_stall=1 for 3 cycles -> no commit, bypass returns 0x55; flush -> x9 keeps old value, instret unchanged.
REQ-034 SHALL test reset mid-operation: x3=0x99 pending, rst=1 -> x3=0, instret=0, wb_valid=0 next cycle.
REQ-035 SHALL test wrap with WB_INSTRET_EN: counter forced to 0xFFFF_FFFF_FFFF_FFFF, one commit -> instret=0; without the macro, instret=0 throughout.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: widths, register index, pending-entry record
// and the EMPTY/FULL state encoding of the writeback slot.
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;

  typedef logic [4:0] reg_index_t;

  typedef struct packed {
    logic            valid;
    reg_index_t      rd;
    logic [XLEN-1:0] data;
    logic            we;
  } wb_entry_t;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/register_file.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, synchronous active-high reset of x1..x31.
module register_file
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  reg_index_t      waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_index_t      raddr1,
  input  reg_index_t      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  // x0 has no storage at all.
  logic [XLEN-1:0] regs [1:REG_COUNT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/writeback_unit.sv
// Single-entry writeback stage with operand bypass to decode and an optional
// 64-bit retired-instruction counter (enabled by defining WB_INSTRET_EN).
//
// Handshake: a result transfers on a rising edge when ex_valid & ex_ready;
// ex_ready depends only on wb_stall, never on ex_valid, and flush discards
// the transfer of that same edge.
module writeback_unit
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  reg_index_t      rd_index,
  input  logic [XLEN-1:0] result,
  input  logic            need_write_rd,
  input  logic            wb_stall,
  input  logic            flush,
  input  reg_index_t      rs1_index,
  input  reg_index_t      rs2_index,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output reg_index_t      wb_rd_index,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [63:0]     instret
);

  wb_entry_t       entry_q, entry_d;
  wb_state_t       state;
  logic            commit;
  logic            capture;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  assign state    = entry_q.valid ? WB_FULL : WB_EMPTY;
  assign ex_ready = ~wb_stall;
  assign capture  = ex_valid & ex_ready & ~flush;
  assign commit   = (state == WB_FULL) & ~wb_stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  // Flush beats stall, stall beats capture; a commit frees the slot unless
  // a new result refills it on the same edge.
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d.valid = 1'b0;
    end else if (!wb_stall) begin
      entry_d.valid = capture;
      if (capture) begin
        entry_d.rd   = rd_index;
        entry_d.data = result;
        entry_d.we   = need_write_rd & (rd_index != '0);
      end
    end
  end

  register_file u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (commit & entry_q.we),
    .waddr  (entry_q.rd),
    .wdata  (entry_q.data),
    .raddr1 (rs1_index),
    .raddr2 (rs2_index),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  assign wb_valid    = commit;
  assign wb_we       = commit & entry_q.we;
  assign wb_rd_index = commit ? entry_q.rd : '0;
  assign wb_data     = commit ? entry_q.data : '0;

  // A stalled entry is still the youngest value for its register.
  function automatic logic [XLEN-1:0] bypass(input reg_index_t idx,
                                             input logic [XLEN-1:0] rf_val);
    if (idx == '0)                                        return '0;
    else if (entry_q.valid && entry_q.we && entry_q.rd == idx) return entry_q.data;
    else                                                  return rf_val;
  endfunction

  assign rs1_data = bypass(rs1_index, rf_rdata1);
  assign rs2_data = bypass(rs2_index, rf_rdata2);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)         instret_q <= '0;
    else if (commit) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a random
// burst, with a commit scoreboard fed at drive time.
module tb_writeback_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  rd_index = '0;
  logic [31:0] result = '0;
  logic        need_write_rd = 1'b0;
  logic        wb_stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_index = '0;
  logic [4:0]  rs2_index = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd_index;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [63:0] instret;

  writeback_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .rd_index      (rd_index),
    .result        (result),
    .need_write_rd (need_write_rd),
    .wb_stall      (wb_stall),
    .flush         (flush),
    .rs1_index     (rs1_index),
    .rs2_index     (rs2_index),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_valid      (wb_valid),
    .wb_rd_index   (wb_rd_index),
    .wb_data       (wb_data),
    .wb_we         (wb_we),
    .instret       (instret)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state: {we, rd, data}
  int          n_cmp = 0;
  int          n_err = 0;
  logic [37:0] exp_q[$];
  logic [37:0] mon_e;
  logic [63:0] exp_count = '0;
  logic [31:0] ref_rf [32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
    return exp_count;
`else
    return 64'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_commit", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("commit_rd",   64'(wb_rd_index), 64'(mon_e[36:32]));
        check_eq("commit_data", 64'(wb_data),     64'(mon_e[31:0]));
        check_eq("commit_we",   64'(wb_we),       64'(mon_e[37]));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] data, input logic need);
    ex_valid      = 1'b1;
    rd_index      = rd;
    result        = data;
    need_write_rd = need;
    if (!wb_stall && !flush && !rst) begin
      exp_q.push_back({need && (rd != 5'd0), rd, data});
      exp_count = exp_count + 64'd1;
      if (need && rd != 5'd0) ref_rf[rd] = data;
    end
    step();
    ex_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic read_rs(input logic [4:0] a, input logic [4:0] b);
    rs1_index = a;
    rs2_index = b;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    read_rs(5'd5, 5'd0);
    check_eq("rst_ex_ready",    64'(ex_ready),    64'd1);
    check_eq("rst_wb_valid",    64'(wb_valid),    64'd0);
    check_eq("rst_wb_we",       64'(wb_we),       64'd0);
    check_eq("rst_wb_rd_index", 64'(wb_rd_index), 64'd0);
    check_eq("rst_wb_data",     64'(wb_data),     64'd0);
    check_eq("rst_rs1_data",    64'(rs1_data),    64'd0);
    check_eq("rst_instret",     instret,          64'd0);
    wb_stall = 1'b1;
    #1;
    check_eq("stall_ex_ready", 64'(ex_ready), 64'd0);
    wb_stall = 1'b0;

    // Back-to-back
    drive(5'd5, 32'h11, 1'b1);
    check_eq("b2b_first_valid", 64'(wb_valid),    64'd1);
    check_eq("b2b_first_rd",    64'(wb_rd_index), 64'd5);
    drive(5'd6, 32'h22, 1'b1);
    check_eq("b2b_second_valid", 64'(wb_valid),    64'd1);
    check_eq("b2b_second_rd",    64'(wb_rd_index), 64'd6);
    drain();
    check_eq("b2b_instret", instret, exp_instret());
    read_rs(5'd5, 5'd6);
    check_eq("b2b_x5", 64'(rs1_data), 64'h11);
    check_eq("b2b_x6", 64'(rs2_data), 64'h22);

    // Bypass of pending entry
    drive(5'd7, 32'hDEADBEEF, 1'b1);
    read_rs(5'd7, 5'd0);
    check_eq("bypass_rs1", 64'(rs1_data), 64'hDEADBEEF);
    check_eq("bypass_rs2_x0", 64'(rs2_data), 64'd0);
    drain();
    read_rs(5'd7, 5'd0);
    check_eq("rf_x7", 64'(rs1_data), 64'hDEADBEEF);

    // Write to x0
    drive(5'd0, 32'h1234, 1'b1);
    check_eq("x0_wb_valid", 64'(wb_valid), 64'd1);
    check_eq("x0_wb_we",    64'(wb_we),    64'd0);
    read_rs(5'd0, 5'd0);
    check_eq("x0_bypass", 64'(rs1_data), 64'd0);
    drain();
    read_rs(5'd0, 5'd0);
    check_eq("x0_read",    64'(rs1_data), 64'd0);
    check_eq("x0_instret", instret, exp_instret());

    // Stall then flush
    drive(5'd9, 32'h55, 1'b1);
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      read_rs(5'd9, 5'd0);
      check_eq("stall_no_commit", 64'(wb_valid), 64'd0);
      check_eq("stall_bypass",    64'(rs1_data), 64'h55);
      step();
    end
    flush = 1'b1;
    wb_stall = 1'b0;
    #1;
    check_eq("flush_no_commit", 64'(wb_valid), 64'd0);
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    exp_count = exp_count - 64'd1;
    ref_rf[9] = 32'h0;
    read_rs(5'd9, 5'd0);
    check_eq("flush_x9",      64'(rs1_data), 64'd0);
    check_eq("flush_valid",   64'(wb_valid), 64'd0);
    check_eq("flush_instret", instret, exp_instret());

    // Reset mid-operation
    drive(5'd3, 32'h99, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_count = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    read_rs(5'd3, 5'd5);
    check_eq("mid_rst_x3",       64'(rs1_data), 64'd0);
    check_eq("mid_rst_x5",       64'(rs2_data), 64'd0);
    check_eq("mid_rst_instret",  instret,       64'd0);
    check_eq("mid_rst_wb_valid", 64'(wb_valid), 64'd0);

    // Random traffic with occasional stalls
    for (int n = 0; n < 80; n++) begin
      wb_stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) != 0)
        drive(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      else
        step();
    end
    wb_stall = 1'b0;
    drain();
    for (int r = 1; r < 32; r++) begin
      read_rs(5'(r), 5'd0);
      check_eq($sformatf("rand_x%0d", r), 64'(rs1_data), 64'(ref_rf[r]));
    end
    check_eq("rand_instret", instret, exp_instret());

    // Counter wrap
`ifdef WB_INSTRET_EN
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.instret_q;
    exp_count = 64'hFFFF_FFFF_FFFF_FFFF;
    check_eq("wrap_preload", instret, exp_count);
    drive(5'd10, 32'hA5, 1'b0);
    drain();
    check_eq("wrap_instret", instret, 64'd0);
`else
    drive(5'd10, 32'hA5, 1'b0);
    drain();
    check_eq("no_counter_instret", instret, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
